uart_rx_buffer: RTL

- Receive-side buffer that sits directly behind uart_rx and drains its single-cycle data_valid / break_received / error strobes.
- Stores each received event in a first-word-fall-through FIFO and presents it to a downstream consumer over a valid/ready handshake.
- Tracks and reports dropped events on overflow, so software or a core-side reader can service the UART without sampling a one-cycle pulse.

---
 rtl/uart_rx_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// FWFT event FIFO behind uart_rx: a strobe pushed at edge N is at the head in cycle N+1; pops retire one per cycle.
// A full FIFO drops new events unless the head leaves in the same cycle; drops are tallied in a sticky, saturating counter.
module uart_rx_buffer #(
  parameter  int Depth      = 16,
  localparam int CountWidth = $clog2(Depth) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_break,
  input  logic                  rx_error,
  output logic [7:0]            data_out,
  output logic                  data_out_break,
  output logic                  data_out_error,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [CountWidth-1:0] count,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clear_overflow
);

  localparam int PtrWidth = $clog2(Depth);

  typedef struct packed {
    logic       err;
    logic       brk;
    logic [7:0] dat;
  } entry_t;

  entry_t                mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_q, drop_d;

  logic   push, pop, full, empty, wr_en, drop;
  entry_t wr_entry, head;

  assign push  = rx_data_valid | rx_break | rx_error;
  assign empty = (count_q == '0);
  assign full  = (count_q == CountWidth'(Depth));
  assign pop   = ~empty & data_out_ready;
  // A full FIFO still accepts when the head is leaving in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wr_entry     = '0;
    wr_entry.err = rx_error;
    wr_entry.brk = rx_break;
    wr_entry.dat = rx_data_valid ? rx_data : 8'h00;
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear wins, restarting the tally at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow)     drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is never cleared; data_out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head           = empty ? entry_t'('0) : mem_q[rd_ptr_q];
  assign data_out       = head.dat;
  assign data_out_break = head.brk;
  assign data_out_error = head.err;
  assign data_out_valid = ~empty;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_q;

endmodule
